// File: rtl/vga_bitmap_scroll.sv
// ============================================================================
// Module   : vga_bitmap_scroll
// Brief    : VGA timing generator that displays a scaled, scrollable bitmap
//            held in an inferred dual-port block RAM with a host write port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_bitmap_scroll #(
    parameter int H_ACTIVE       = 640,
    parameter int H_FP           = 16,
    parameter int H_SYNC         = 96,
    parameter int H_BP           = 48,
    parameter int V_ACTIVE       = 480,
    parameter int V_FP           = 10,
    parameter int V_SYNC         = 2,
    parameter int V_BP           = 29,
    parameter int IMG_W          = 160,
    parameter int IMG_H          = 120,
    parameter int SCALE_LOG2     = 2,
    parameter int CBITS          = 2,
    parameter int BORDER         = 0,
    parameter bit WR_VBLANK_ONLY = 1'b0
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic [$clog2(IMG_W)-1:0]            scroll_x,
    input  logic [$clog2(IMG_H)-1:0]            scroll_y,
    input  logic                                wr_valid,
    input  logic [$clog2(IMG_W*IMG_H)-1:0]      wr_addr,
    input  logic [3*CBITS-1:0]                  wr_data,
    output logic                                wr_ready,
    output logic [CBITS-1:0]                    vga_r,
    output logic [CBITS-1:0]                    vga_g,
    output logic [CBITS-1:0]                    vga_b,
    output logic                                vga_hsync,
    output logic                                vga_vsync,
    output logic                                frame_start,
    output logic [15:0]                         frame_cnt
);

    localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int c_HW      = $clog2(c_H_TOTAL);
    localparam int c_VW      = $clog2(c_V_TOTAL);
    localparam int c_XW      = $clog2(IMG_W);
    localparam int c_YW      = $clog2(IMG_H);
    localparam int c_DEPTH   = IMG_W * IMG_H;
    localparam int c_AW      = $clog2(c_DEPTH);
    localparam int c_DW      = 3 * CBITS;

    localparam logic [c_HW-1:0] c_H_LAST    = c_HW'(c_H_TOTAL - 1);
    localparam logic [c_VW-1:0] c_V_LAST    = c_VW'(c_V_TOTAL - 1);
    localparam logic [c_HW-1:0] c_H_START   = c_HW'(H_SYNC + H_BP);
    localparam logic [c_HW-1:0] c_H_END     = c_HW'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [c_VW-1:0] c_V_START   = c_VW'(V_SYNC + V_BP);
    localparam logic [c_VW-1:0] c_V_END     = c_VW'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [c_HW-1:0] c_H_SYNC_W  = c_HW'(H_SYNC);
    localparam logic [c_VW-1:0] c_V_SYNC_W  = c_VW'(V_SYNC);
    localparam logic [c_HW-1:0] c_IMG_W_H   = c_HW'(IMG_W);
    localparam logic [c_VW-1:0] c_IMG_H_V   = c_VW'(IMG_H);
    localparam logic [c_XW:0]   c_IMG_W_X   = (c_XW+1)'(IMG_W);
    localparam logic [c_YW:0]   c_IMG_H_Y   = (c_YW+1)'(IMG_H);
    localparam logic [c_AW:0]   c_DEPTH_A   = (c_AW+1)'(c_DEPTH);
    localparam logic [c_AW-1:0] c_IMG_W_A   = c_AW'(IMG_W);
    localparam logic [c_DW-1:0] c_BORDER    = BORDER[c_DW-1:0];

    // Raster counters and per-frame scroll shadows
    logic [c_HW-1:0]  r_hc;
    logic [c_VW-1:0]  r_vc;
    logic [c_XW-1:0]  r_xs;
    logic [c_YW-1:0]  r_ys;

    // Pipeline stage 1 (address register) and stage 2 (RAM/output register)
    logic [c_AW-1:0]  r_addr;
    logic             r_act1, r_brd1, r_hs1, r_vs1, r_fs1;
    logic             r_act2, r_brd2, r_hs2, r_vs2, r_fs2;
    logic [c_DW-1:0]  r_rd_data;
    logic [15:0]      r_frame_cnt;

    logic [c_DW-1:0]  r_mem [0:c_DEPTH-1];

    logic             w_h_act, w_v_act, w_active, w_in_img, w_frame_top;
    logic [c_HW-1:0]  w_px, w_sx;
    logic [c_VW-1:0]  w_py, w_sy;
    logic [c_XW:0]    w_xsum;
    logic [c_YW:0]    w_ysum;
    logic [c_XW-1:0]  w_x_src;
    logic [c_YW-1:0]  w_y_src;
    logic [c_AW-1:0]  w_addr;
    logic             w_wr_fire, w_wr_in_range;
    logic [c_DW-1:0]  w_rgb;

    assign w_frame_top = (r_hc == '0) && (r_vc == '0);

    always_comb begin
        w_h_act  = (r_hc >= c_H_START) && (r_hc < c_H_END);
        w_v_act  = (r_vc >= c_V_START) && (r_vc < c_V_END);
        w_active = w_h_act && w_v_act;
        w_px     = r_hc - c_H_START;
        w_py     = r_vc - c_V_START;
        w_sx     = w_px >> SCALE_LOG2;
        w_sy     = w_py >> SCALE_LOG2;
        w_in_img = (w_sx < c_IMG_W_H) && (w_sy < c_IMG_H_V);

        // Source coordinates are below the image size here, so one subtract wraps them
        w_xsum = {1'b0, c_XW'(w_sx)} + {1'b0, r_xs};
        w_ysum = {1'b0, c_YW'(w_sy)} + {1'b0, r_ys};
        w_x_src = (w_xsum >= c_IMG_W_X) ? c_XW'(w_xsum - c_IMG_W_X) : c_XW'(w_xsum);
        w_y_src = (w_ysum >= c_IMG_H_Y) ? c_YW'(w_ysum - c_IMG_H_Y) : c_YW'(w_ysum);
        w_addr  = c_AW'(w_y_src) * c_IMG_W_A + c_AW'(w_x_src);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (r_hc == c_H_LAST) begin
            r_hc <= '0;
            r_vc <= (r_vc == c_V_LAST) ? '0 : r_vc + 1'b1;
        end else begin
            r_hc <= r_hc + 1'b1;
        end
    end

    // Out-of-range scroll requests leave the previous offset in place
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_xs <= '0;
            r_ys <= '0;
        end else if (w_frame_top) begin
            if ({1'b0, scroll_x} < c_IMG_W_X) begin
                r_xs <= scroll_x;
            end
            if ({1'b0, scroll_y} < c_IMG_H_Y) begin
                r_ys <= scroll_y;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_addr      <= '0;
            r_act1      <= 1'b0;
            r_brd1      <= 1'b0;
            r_hs1       <= 1'b1;
            r_vs1       <= 1'b1;
            r_fs1       <= 1'b0;
            r_act2      <= 1'b0;
            r_brd2      <= 1'b0;
            r_hs2       <= 1'b1;
            r_vs2       <= 1'b1;
            r_fs2       <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            if (w_active && w_in_img) begin
                r_addr <= w_addr;
            end
            r_act1 <= w_active;
            r_brd1 <= w_active && !w_in_img;
            r_hs1  <= (r_hc >= c_H_SYNC_W);
            r_vs1  <= (r_vc >= c_V_SYNC_W);
            r_fs1  <= w_frame_top;
            r_act2 <= r_act1;
            r_brd2 <= r_brd1;
            r_hs2  <= r_hs1;
            r_vs2  <= r_vs1;
            r_fs2  <= r_fs1;
            if (r_fs1) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
        end
    end

    assign w_wr_fire     = wr_valid && wr_ready;
    assign w_wr_in_range = ({1'b0, wr_addr} < c_DEPTH_A);

    // Read-before-write: a same-address collision returns the old word
    always_ff @(posedge clk) begin
        if (w_wr_fire && w_wr_in_range) begin
            r_mem[wr_addr] <= wr_data;
        end
        r_rd_data <= r_mem[r_addr];
    end

    assign w_rgb = r_act2 ? (r_brd2 ? c_BORDER : r_rd_data) : '0;

    assign wr_ready    = resetn && (!WR_VBLANK_ONLY || !w_v_act);
    assign vga_r       = w_rgb[3*CBITS-1:2*CBITS];
    assign vga_g       = w_rgb[2*CBITS-1:CBITS];
    assign vga_b       = w_rgb[CBITS-1:0];
    assign vga_hsync   = r_hs2;
    assign vga_vsync   = r_vs2;
    assign frame_start = r_fs2;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_bitmap_scroll.sv
// ============================================================================
// Module   : tb_vga_bitmap_scroll
// Brief    : Directed self-checking bench on a reduced raster (25x17 clocks).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_bitmap_scroll;

    localparam int HT = 25;
    localparam int VT = 17;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] scroll_x, scroll_y;
    logic       wr_valid;
    logic [4:0] wr_addr;
    logic [5:0] wr_data;
    logic       wr_ready;
    logic [1:0] vga_r, vga_g, vga_b;
    logic       vga_hsync, vga_vsync, frame_start;
    logic [15:0] frame_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    vga_bitmap_scroll #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
        .V_ACTIVE(12), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .IMG_W(6), .IMG_H(5), .SCALE_LOG2(1), .CBITS(2),
        .BORDER(6'h30), .WR_VBLANK_ONLY(1'b1)
    ) dut (
        .clk(clk), .resetn(resetn),
        .scroll_x(scroll_x), .scroll_y(scroll_y),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ready(wr_ready),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync),
        .frame_start(frame_start), .frame_cnt(frame_cnt)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_fs();
        bit seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check("frame_start_seen", 16'(seen), 16'd1);
    endtask

    // Output at k cycles after the frame_start cycle belongs to raster hc/vc = k
    task automatic check_at(input string tag, input int hc, input int vc, input logic [5:0] exp);
        wait_fs();
        skip(vc * HT + hc);
        check(tag, 16'({vga_r, vga_g, vga_b}), 16'(exp));
    endtask

    task automatic host_write(input int a, input logic [5:0] d);
        bit ok = 1'b0;
        wr_valid = 1'b1;
        wr_addr  = 5'(a);
        wr_data  = d;
        for (int i = 0; i < 1000; i++) begin
            if (wr_ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        wr_valid = 1'b0;
        check("write_ack", 16'(ok), 16'd1);
    endtask

    initial begin
        int hs_lo, vs_lo, fs_n, n;
        resetn   = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        scroll_x = 3'd0;
        scroll_y = 3'd0;
        skip(3);

        check("rst_hsync", 16'(vga_hsync), 16'd1);
        check("rst_vsync", 16'(vga_vsync), 16'd1);
        check("rst_rgb", 16'({vga_r, vga_g, vga_b}), 16'd0);
        check("rst_frame_cnt", frame_cnt, 16'd0);
        check("rst_frame_start", 16'(frame_start), 16'd0);
        check("rst_wr_ready", 16'(wr_ready), 16'd0);

        resetn = 1'b1;
        wait_fs();
        check("first_frame_cnt", frame_cnt, 16'd1);
        check("first_hsync_low", 16'(vga_hsync), 16'd0);
        check("first_vsync_low", 16'(vga_vsync), 16'd0);

        // One full frame of sync and pulse statistics
        hs_lo = 0; vs_lo = 0; fs_n = 0;
        for (int i = 0; i < HT * VT; i++) begin
            if (vga_hsync === 1'b0) hs_lo++;
            if (vga_vsync === 1'b0) vs_lo++;
            if (frame_start === 1'b1) fs_n++;
            @(negedge clk);
        end
        check("hsync_low_clocks", 16'(hs_lo), 16'd68);
        check("vsync_low_clocks", 16'(vs_lo), 16'd50);
        check("frame_start_pulses", 16'(fs_n), 16'd1);
        check("second_frame_start", 16'(frame_start), 16'd1);
        check("second_frame_cnt", frame_cnt, 16'd2);

        // Write requested during active lines stalls until vc reaches 16
        skip(150);
        wr_valid = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 6'h3F;
        check("wr_ready_active", 16'(wr_ready), 16'd0);
        n = 0;
        while (wr_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("wr_ready_wait", 16'(n), 16'd248);
        @(negedge clk);
        wr_valid = 1'b0;

        for (int a = 1; a < 30; a++) begin
            host_write(a, 6'(63 - a));
        end
        host_write(30, 6'h00);

        check_at("pix_0_0", 7, 4, 6'h3F);
        check_at("pix_1_1", 8, 5, 6'h3F);
        check_at("pix_2_0", 9, 4, 6'h3E);
        check_at("pix_11_9", 18, 13, 6'h22);
        check_at("border_right", 19, 4, 6'h30);
        check_at("border_bottom", 7, 14, 6'h30);
        check_at("border_last", 22, 15, 6'h30);
        check_at("blank_before", 6, 4, 6'h00);
        check_at("blank_after", 23, 4, 6'h00);
        check_at("blank_vblank", 7, 16, 6'h00);

        wait_fs();
        skip(5 * HT + 3);
        check("hsync_last_low", 16'(vga_hsync), 16'd0);
        skip(1);
        check("hsync_first_high", 16'(vga_hsync), 16'd1);

        // Scroll change mid-frame must wait for the next frame
        wait_fs();
        skip(10);
        scroll_x = 3'd5;
        scroll_y = 3'd4;
        skip(4 * HT + 7 - 10);
        check("scroll_same_frame", 16'({vga_r, vga_g, vga_b}), 16'h3F);
        check_at("scroll_0_0", 7, 4, 6'h22);
        check_at("scroll_2_2", 9, 6, 6'h3F);
        check_at("scroll_2_0", 9, 4, 6'h27);
        check_at("scroll_11_9", 18, 13, 6'h29);

        scroll_x = 3'd6;
        scroll_y = 3'd7;
        check_at("scroll_oor_0_0", 7, 4, 6'h22);
        check_at("scroll_oor_2_0", 9, 4, 6'h27);

        // Reset while both syncs are low
        wait_fs();
        skip(1);
        resetn = 1'b0;
        @(negedge clk);
        check("midrst_hsync", 16'(vga_hsync), 16'd1);
        check("midrst_vsync", 16'(vga_vsync), 16'd1);
        check("midrst_rgb", 16'({vga_r, vga_g, vga_b}), 16'd0);
        check("midrst_frame_cnt", frame_cnt, 16'd0);
        check("midrst_wr_ready", 16'(wr_ready), 16'd0);
        skip(2);
        resetn = 1'b1;
        wait_fs();
        check("postrst_frame_cnt", frame_cnt, 16'd1);
        skip(4 * HT + 7);
        check("postrst_pix_0_0", 16'({vga_r, vga_g, vga_b}), 16'h3F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
